// File: rtl/ice40_spi_slave_controller_pkg.sv
// Shared definitions for the iCE40 SB_SPI slave sequencer: the hard-IP
// register map, status-register bit positions and control-register values.
package ice40_spi_slave_controller_pkg;

    // SB_SPI system-bus register addresses
    localparam logic [7:0] SPICR0_ADDR  = 8'h08;
    localparam logic [7:0] SPICR1_ADDR  = 8'h09;
    localparam logic [7:0] SPICR2_ADDR  = 8'h0A;
    localparam logic [7:0] SPIBR_ADDR   = 8'h0B;
    localparam logic [7:0] SPISR_ADDR   = 8'h0C;
    localparam logic [7:0] SPITXDR_ADDR = 8'h0D;
    localparam logic [7:0] SPIRXDR_ADDR = 8'h0E;
    localparam logic [7:0] SPICSR_ADDR  = 8'h0F;

    // SPISR bit positions
    localparam int SR_TRDY_BIT = 4;
    localparam int SR_RRDY_BIT = 3;
    localparam int SR_ROE_BIT  = 1;

    // Fixed control-register contents
    localparam logic [7:0] SPICR0_VALUE = 8'h00;
    localparam logic [7:0] SPICR1_SPE   = 8'h80;

    // SPICR2 for slave mode: MSTR clear, mode bits in the low three bits
    function automatic logic [7:0] spi_cr2_value(input logic cpol,
                                                 input logic cpha,
                                                 input logic lsb_first);
        return {1'b0, 4'b0000, cpol, cpha, lsb_first};
    endfunction

endpackage

// File: rtl/ice40_spi_sbus_access.sv
// One strobe/ack transaction on the SB_SPI system bus.
// Handshake: while req is high and no access is in flight, the request
// (addr, rw, wdata) is registered onto the bus and spi_strobe rises on the
// next cycle; the bus signals then stay frozen until spi_ack is sampled high.
// done is high exactly in that ack cycle (rdata is the bus read data then),
// and strobe is registered low at the same edge, so it is low for at least
// one cycle before the next access can launch.
module ice40_spi_sbus_access (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [7:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    input  logic [7:0] spi_data_out,
    input  logic       spi_ack,
    output logic       spi_rw,
    output logic [7:0] spi_reg_addr,
    output logic       spi_strobe,
    output logic [7:0] spi_data_in
);

    // Completion is the ack seen while our own strobe is up; a stray ack is ignored
    assign done  = spi_strobe && spi_ack;
    assign rdata = spi_data_out;

    // Launch a request, hold it stable, drop strobe in the ack cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_strobe   <= 1'b0;
            spi_rw       <= 1'b0;
            spi_reg_addr <= 8'h00;
            spi_data_in  <= 8'h00;
        end else if (spi_strobe) begin
            if (spi_ack) begin
                spi_strobe <= 1'b0;
            end
        end else if (req) begin
            spi_strobe   <= 1'b1;
            spi_rw       <= rw;
            spi_reg_addr <= addr;
            spi_data_in  <= wdata;
        end
    end

endmodule

// File: rtl/ice40_spi_slave_controller.sv
// SB_SPI slave sequencer: configures the hard IP for slave mode, then polls
// SPISR, delivering received bytes on rx_* and keeping SPITXDR loaded from
// a one-entry reply holding register fed by tx_*.
// Optional feature: define ICE40_SPI_SLAVE_OVERRUN_EN to add the sticky
// rx_overrun flag (set by ROE on any SPISR read, cleared only by reset).
// Stream handshakes (rx_* and tx_*): a byte moves on the clock edge where
// valid && ready are both high; valid never drops and data never changes
// while waiting for ready.
module ice40_spi_slave_controller
    import ice40_spi_slave_controller_pkg::*;
#(
    parameter logic       CPOL         = 1'b0,
    parameter logic       CPHA         = 1'b0,
    parameter logic       LSB_FIRST    = 1'b0,
    parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] spi_data_out,
    input  logic       spi_ack,
    output logic       spi_rw,
    output logic [7:0] spi_reg_addr,
    output logic       spi_strobe,
    output logic [7:0] spi_data_in,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
`ifdef ICE40_SPI_SLAVE_OVERRUN_EN
    output logic       rx_overrun,
`endif
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        ST_CFG_CR0  = 4'd0,
        ST_CFG_CR1  = 4'd1,
        ST_CFG_CR2  = 4'd2,
        ST_CFG_TX   = 4'd3,
        ST_POLL     = 4'd4,
        ST_READ_RX  = 4'd5,
        ST_DELIVER  = 4'd6,
        ST_WRITE_TX = 4'd7
    } state_t;

    state_t     state;
    logic       acc_req;
    logic [7:0] acc_addr;
    logic       acc_rw;
    logic [7:0] acc_wdata;
    logic       acc_done;
    logic [7:0] acc_rdata;
    logic [7:0] tx_hold;   // reply byte waiting for TRDY (full when tx_ready is 0)
    logic [7:0] tx_byte;   // byte chosen for the current SPITXDR write
    logic       tx_accept;

    assign debug_state = state;
    // tx_ready is only ever 1 after configuration, so this is the whole accept rule
    assign tx_accept   = tx_valid && tx_ready;

    // Bus request implied by the current state; DELIVER issues nothing
    always_comb begin
        acc_req   = 1'b0;
        acc_addr  = 8'h00;
        acc_rw    = 1'b0;
        acc_wdata = 8'h00;
        case (state)
            ST_CFG_CR0: begin
                acc_req   = 1'b1;
                acc_addr  = SPICR0_ADDR;
                acc_rw    = 1'b1;
                acc_wdata = SPICR0_VALUE;
            end
            ST_CFG_CR1: begin
                acc_req   = 1'b1;
                acc_addr  = SPICR1_ADDR;
                acc_rw    = 1'b1;
                acc_wdata = SPICR1_SPE;
            end
            ST_CFG_CR2: begin
                acc_req   = 1'b1;
                acc_addr  = SPICR2_ADDR;
                acc_rw    = 1'b1;
                acc_wdata = spi_cr2_value(CPOL, CPHA, LSB_FIRST);
            end
            ST_CFG_TX: begin
                acc_req   = 1'b1;
                acc_addr  = SPITXDR_ADDR;
                acc_rw    = 1'b1;
                acc_wdata = TX_IDLE_BYTE;
            end
            ST_POLL: begin
                acc_req   = 1'b1;
                acc_addr  = SPISR_ADDR;
            end
            ST_READ_RX: begin
                acc_req   = 1'b1;
                acc_addr  = SPIRXDR_ADDR;
            end
            ST_WRITE_TX: begin
                acc_req   = 1'b1;
                acc_addr  = SPITXDR_ADDR;
                acc_rw    = 1'b1;
                acc_wdata = tx_byte;
            end
            default: begin
                acc_req   = 1'b0;
            end
        endcase
    end

    ice40_spi_sbus_access u_access (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (acc_req),
        .addr         (acc_addr),
        .rw           (acc_rw),
        .wdata        (acc_wdata),
        .done         (acc_done),
        .rdata        (acc_rdata),
        .spi_data_out (spi_data_out),
        .spi_ack      (spi_ack),
        .spi_rw       (spi_rw),
        .spi_reg_addr (spi_reg_addr),
        .spi_strobe   (spi_strobe),
        .spi_data_in  (spi_data_in)
    );

    // Sequencer: configuration, SR polling, RX delivery and TX reply draining.
    // The reply byte is picked when the SR read sends us to WRITE_TX, so it is
    // stable for the whole write; a byte captured in that same cycle stays held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_CFG_CR0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            tx_hold  <= 8'h00;
            tx_byte  <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            case (state)
                ST_CFG_CR0: if (acc_done) state <= ST_CFG_CR1;
                ST_CFG_CR1: if (acc_done) state <= ST_CFG_CR2;
                ST_CFG_CR2: if (acc_done) state <= ST_CFG_TX;
                ST_CFG_TX: begin
                    if (acc_done) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (acc_done) begin
                        if (acc_rdata[SR_RRDY_BIT]) begin
                            state <= ST_READ_RX;
                        end else if (acc_rdata[SR_TRDY_BIT]) begin
                            state <= ST_WRITE_TX;
                            if (!tx_ready) begin
                                tx_byte  <= tx_hold;
                                tx_ready <= 1'b1;
                            end else begin
                                tx_byte  <= TX_IDLE_BYTE;
                            end
                        end
                    end
                end
                ST_READ_RX: begin
                    if (acc_done) begin
                        rx_data  <= acc_rdata;
                        rx_valid <= 1'b1;
                        state    <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (rx_valid && rx_ready) begin
                        rx_valid <= 1'b0;
                        state    <= ST_POLL;
                    end
                end
                ST_WRITE_TX: if (acc_done) state <= ST_POLL;
                default: begin
                    busy  <= 1'b1;
                    state <= ST_CFG_CR0;
                end
            endcase
            if (tx_accept) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

`ifdef ICE40_SPI_SLAVE_OVERRUN_EN
    // Sticky overrun: any SR read reporting ROE sets it until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_overrun <= 1'b0;
        end else if (state == ST_POLL && acc_done && acc_rdata[SR_ROE_BIT]) begin
            rx_overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ice40_spi_slave_controller.sv
// Bench for ice40_spi_slave_controller: SB_SPI bus model answering SR/RXDR
// reads from scripted queues, a monitor checking every non-SR bus access and
// every delivered RX byte against expected queues, and randomized traffic.
module tb_ice40_spi_slave_controller;

  localparam logic [7:0] A_CR0  = 8'h08;
  localparam logic [7:0] A_CR1  = 8'h09;
  localparam logic [7:0] A_CR2  = 8'h0A;
  localparam logic [7:0] A_SR   = 8'h0C;
  localparam logic [7:0] A_TXDR = 8'h0D;
  localparam logic [7:0] A_RXDR = 8'h0E;
  localparam logic [7:0] IDLE_B = 8'hFF;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] spi_data_out;
  logic       spi_ack;
  logic       spi_rw;
  logic [7:0] spi_reg_addr;
  logic       spi_strobe;
  logic [7:0] spi_data_in;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] debug_state;
`ifdef ICE40_SPI_SLAVE_OVERRUN_EN
  logic       rx_overrun;
`endif

  int tests_run = 0;
  int failed = 0;
  int ack_lat = 2;
  int wait_cnt = 0;

  logic [16:0] exp_acc_q[$];   // {rw, addr, write data or 0 for reads}
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  sr_q[$];
  logic [7:0]  rxdr_q[$];
  logic [7:0]  pending_q[$];   // model of the reply holding register

  always #5 clk = ~clk;

  ice40_spi_slave_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_data_out (spi_data_out),
    .spi_ack      (spi_ack),
    .spi_rw       (spi_rw),
    .spi_reg_addr (spi_reg_addr),
    .spi_strobe   (spi_strobe),
    .spi_data_in  (spi_data_in),
    .busy         (busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
`ifdef ICE40_SPI_SLAVE_OVERRUN_EN
    .rx_overrun   (rx_overrun),
`endif
    .debug_state  (debug_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus model: ack after ack_lat extra strobe cycles; reads come from queues
  initial begin
    spi_ack = 1'b0;
    spi_data_out = 8'h00;
    forever begin
      @(negedge clk);
      spi_ack = 1'b0;
      if (reset_n && spi_strobe) begin
        if (wait_cnt >= ack_lat) begin
          spi_ack = 1'b1;
          wait_cnt = 0;
          if (!spi_rw) begin
            if (spi_reg_addr == A_SR)
              spi_data_out = (sr_q.size() > 0) ? sr_q.pop_front() : 8'h00;
            else if (spi_reg_addr == A_RXDR)
              spi_data_out = (rxdr_q.size() > 0) ? rxdr_q.pop_front() : 8'h00;
            else
              spi_data_out = 8'h00;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compare completed bus accesses and RX handshakes with expectations
  initial begin
    logic [16:0] obs;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && spi_strobe && spi_ack && spi_reg_addr != A_SR) begin
        obs = {spi_rw, spi_reg_addr, spi_rw ? spi_data_in : 8'h00};
        if (exp_acc_q.size() == 0) begin
          tests_run++;
          failed++;
          $display("FAIL unexpected_access: got %0h expected none at %0t", obs, $time);
        end else begin
          e = exp_acc_q.pop_front();
          check("bus_access", {15'd0, obs}, {15'd0, e});
        end
      end
      if (reset_n && rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) begin
          tests_run++;
          failed++;
          $display("FAIL unexpected_rx: got %0h expected none at %0t", rx_data, $time);
        end else begin
          check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sr_q.size() != 0 || exp_acc_q.size() != 0 || exp_rx_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, (n >= 300) ? 32'd1 : 32'd0, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_config();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("config_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    check("config_writes_left", exp_acc_q.size(), 0);
    check("busy_after_cfg", {31'd0, busy}, 32'd0);
    check("tx_ready_after_cfg", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic push_config();
    exp_acc_q.push_back({1'b1, A_CR0, 8'h00});
    exp_acc_q.push_back({1'b1, A_CR1, 8'h80});
    exp_acc_q.push_back({1'b1, A_CR2, 8'h00});
    exp_acc_q.push_back({1'b1, A_TXDR, IDLE_B});
  endtask

  // Offer one reply byte once the holding register is empty
  task automatic offer_tx(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    if (n < 200) begin
      tx_valid = 1'b1;
      tx_data = b;
      pending_q.push_back(b);
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_fall", {31'd0, tx_ready}, 32'd0);
    end
  endtask

  // One slave-side event: the SR value the hard IP reports, plus the RX byte.
  // RRDY wins; TRDY stays set in the hardware, so it is reported again after.
  task automatic do_event(input logic [7:0] sr, input logic [7:0] rxb, input int hold);
    logic [7:0] b;
    int n;
    int strobes;
    sr_q.push_back(sr);
    if (sr[3]) begin
      rxdr_q.push_back(rxb);
      exp_acc_q.push_back({1'b0, A_RXDR, 8'h00});
      exp_rx_q.push_back(rxb);
      if (sr[4]) sr_q.push_back(sr & 8'hF7);
    end
    if (sr[4]) begin
      b = (pending_q.size() > 0) ? pending_q.pop_front() : IDLE_B;
      exp_acc_q.push_back({1'b1, A_TXDR, b});
    end
    if (sr[3]) begin
      n = 0;
      while (!rx_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rx_valid_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
      strobes = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (spi_strobe) strobes++;
      end
      if (hold > 0) begin
        check("deliver_no_bus", strobes, 0);
        check("rx_valid_held", {31'd0, rx_valid}, 32'd1);
        check("rx_data_held", {24'd0, rx_data}, {24'd0, rxb});
      end
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("rx_valid_clear", {31'd0, rx_valid}, 32'd0);
    end
    wait_drain("event");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sr;
    reset_n = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_strobe", {31'd0, spi_strobe}, 32'd0);
    check("rst_rw", {31'd0, spi_rw}, 32'd0);
    check("rst_addr", {24'd0, spi_reg_addr}, 32'd0);
    check("rst_wdata", {24'd0, spi_data_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rx", {23'd0, rx_valid, rx_data}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
`ifdef ICE40_SPI_SLAVE_OVERRUN_EN
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
`endif

    // Configuration with a 2-cycle bus
    ack_lat = 2;
    push_config();
    reset_n = 1'b1;
    wait_config();

    // Directed traffic
    do_event(8'h08, 8'hA5, 10);
    offer_tx(8'h3C);
    do_event(8'h10, 8'h00, 0);
    check("tx_ready_after_drain", {31'd0, tx_ready}, 32'd1);
    do_event(8'h10, 8'h00, 0);
    do_event(8'h18, 8'h5A, 3);

    // Randomized traffic with varying bus latency
    for (int i = 0; i < 30; i++) begin
      ack_lat = $urandom_range(0, 3);
      if (pending_q.size() == 0 && $urandom_range(0, 1) == 1)
        offer_tx(8'($urandom_range(0, 255)));
      sr = 8'($urandom_range(0, 255)) & 8'hE5;  // ignored bits only, no ROE
      sr[3] = 1'($urandom_range(0, 1));
      sr[4] = 1'($urandom_range(0, 1));
      do_event(sr, 8'($urandom_range(0, 255)), $urandom_range(0, 4));
    end

    // Reset while a strobe waits for ack, with a reply byte pending
    ack_lat = 2;
    if (pending_q.size() == 0) offer_tx(8'h77);
    ack_lat = 40;
    begin
      int n = 0;
      while (!spi_strobe && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("strobe_seen", {31'd0, spi_strobe}, 32'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_strobe_drop", {31'd0, spi_strobe}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd1);
    check("async_tx_ready", {31'd0, tx_ready}, 32'd0);
    sr_q.delete();
    rxdr_q.delete();
    pending_q.delete();
    exp_acc_q.delete();
    exp_rx_q.delete();
    push_config();
    ack_lat = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_config();
    do_event(8'h10, 8'h00, 0);

`ifdef ICE40_SPI_SLAVE_OVERRUN_EN
    do_event(8'h02, 8'h00, 0);
    check("overrun_set", {31'd0, rx_overrun}, 32'd1);
    do_event(8'h00, 8'h00, 0);
    do_event(8'h00, 8'h00, 0);
    check("overrun_sticky", {31'd0, rx_overrun}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
